// File: rtl/axi_burst_ram_slave.sv
// rtl/axi_burst_ram_slave.sv - AXI4 FIXED/INCR/WRAP burst RAM slave; AXI_SLV_ERRCHK_EN enables SLVERR checking
module axi_burst_ram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int                STRB_W   = DATA_W / 8;
    localparam int                LSB      = $clog2(STRB_W);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [2:0]        MAX_SIZE = 3'(LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    w_state_t          r_wstate;
    logic              r_awready, r_wready, r_bvalid;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen, r_wcnt;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;

    r_state_t          r_rstate;
    logic              r_arready, r_rvalid, r_rlast;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen, r_rcnt;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;

    function automatic logic [2:0] f_clamp(input logic [2:0] sz);
        return (sz > MAX_SIZE) ? MAX_SIZE : sz;
    endfunction

    function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
        return a & ({ADDR_W{1'b1}} << sz);
    endfunction

    // Address of the beat following 'a'; 'a' is already size-aligned
    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                 input logic [7:0] len, input logic [1:0] bt);
        logic [ADDR_W-1:0] step, wmask;
        step  = ADDR_W'(1) << sz;
        wmask = (step * (ADDR_W'(len) + ADDR_W'(1))) - ADDR_W'(1);
        if (bt == 2'b00)
            return a;
        if (bt == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return (a & ~wmask) | ((a + step) & wmask);
        return a + step;
    endfunction

    function automatic logic f_oor(input logic [ADDR_W-1:0] a);
        return (a >> LSB) >= DEPTH_A;
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
`ifdef AXI_SLV_ERRCHK_EN
        return IDX_W'(a >> LSB);
`else
        return IDX_W'((a >> LSB) % DEPTH_A);
`endif
    endfunction

    logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic              w_wlast_beat, w_mem_we;
    logic [2:0]        w_awsize_c, w_arsize_c;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_word;
    logic [IDX_W-1:0]  w_widx;

    assign w_aw_hs      = r_awready & s_axi_awvalid;
    assign w_w_hs       = r_wready & s_axi_wvalid;
    assign w_b_hs       = r_bvalid & s_axi_bready;
    assign w_ar_hs      = r_arready & s_axi_arvalid;
    assign w_r_hs       = r_rvalid & s_axi_rready;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_awsize_c   = f_clamp(s_axi_awsize);
    assign w_arsize_c   = f_clamp(s_axi_arsize);
    assign w_widx       = f_index(r_waddr);
    assign w_rd_addr    = (r_rstate == R_IDLE) ? f_align(s_axi_araddr, w_arsize_c)
                                               : f_next(r_raddr, r_rsize, r_rlen, r_rburst);
    assign w_rd_word    = r_mem[f_index(w_rd_addr)];

`ifdef AXI_SLV_ERRCHK_EN
    logic r_wburst_err, r_rburst_err;
    logic w_aw_err, w_ar_err, w_wbeat_err, w_rbeat_err;
    assign w_aw_err    = (s_axi_awburst == 2'b11) | (s_axi_awsize > MAX_SIZE);
    assign w_ar_err    = (s_axi_arburst == 2'b11) | (s_axi_arsize > MAX_SIZE);
    assign w_wbeat_err = r_wburst_err | f_oor(r_waddr) | (s_axi_wlast != w_wlast_beat);
    assign w_rbeat_err = ((r_rstate == R_IDLE) ? w_ar_err : r_rburst_err) | f_oor(w_rd_addr);
    assign w_mem_we    = w_w_hs & ~r_wburst_err & ~f_oor(r_waddr);
`else
    logic w_unused;
    assign w_unused = ^{s_axi_wlast, f_oor(r_waddr)};
    assign w_mem_we = w_w_hs;
`endif

    // Byte-enabled memory write; no reset so contents survive ARESETn
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < STRB_W; b++)
            if (w_mem_we && s_axi_wstrb[b])
                r_mem[w_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end

    // Write channel FSM: AW latch, beat-counted W data, B response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate <= W_IDLE; r_awready <= 1'b0; r_wready <= 1'b0; r_bvalid <= 1'b0;
            r_bid <= '0; r_bresp <= 2'b00; r_waddr <= '0; r_wlen <= '0; r_wcnt <= '0;
            r_wsize <= '0; r_wburst <= '0;
`ifdef AXI_SLV_ERRCHK_EN
            r_wburst_err <= 1'b0;
`endif
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= s_axi_awid;
                        r_bresp   <= 2'b00;
                        r_waddr   <= f_align(s_axi_awaddr, w_awsize_c);
                        r_wlen    <= s_axi_awlen;
                        r_wsize   <= w_awsize_c;
                        r_wburst  <= s_axi_awburst;
                        r_wcnt    <= 8'd0;
`ifdef AXI_SLV_ERRCHK_EN
                        r_wburst_err <= w_aw_err;
`endif
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
`ifdef AXI_SLV_ERRCHK_EN
                        r_bresp <= r_bresp | {w_wbeat_err, 1'b0};
`endif
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                        end else begin
                            r_waddr <= f_next(r_waddr, r_wsize, r_wlen, r_wburst);
                            r_wcnt  <= r_wcnt + 8'd1;
                        end
                    end
                end
                default: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read channel FSM: registered R beat, advanced on each handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate <= R_IDLE; r_arready <= 1'b0; r_rvalid <= 1'b0; r_rlast <= 1'b0;
            r_rid <= '0; r_rdata <= '0; r_rresp <= 2'b00; r_raddr <= '0; r_rlen <= '0;
            r_rcnt <= '0; r_rsize <= '0; r_rburst <= '0;
`ifdef AXI_SLV_ERRCHK_EN
            r_rburst_err <= 1'b0;
`endif
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= s_axi_arid;
                        r_raddr   <= w_rd_addr;
                        r_rlen    <= s_axi_arlen;
                        r_rsize   <= w_arsize_c;
                        r_rburst  <= s_axi_arburst;
                        r_rcnt    <= 8'd0;
                        r_rlast   <= (s_axi_arlen == 8'd0);
`ifdef AXI_SLV_ERRCHK_EN
                        r_rburst_err <= w_ar_err;
                        r_rdata   <= w_rbeat_err ? '0 : w_rd_word;
                        r_rresp   <= {w_rbeat_err, 1'b0};
`else
                        r_rdata   <= w_rd_word;
                        r_rresp   <= 2'b00;
`endif
                        r_rstate  <= R_DATA;
                    end
                end
                default: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= w_rd_addr;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
`ifdef AXI_SLV_ERRCHK_EN
                            r_rdata <= w_rbeat_err ? '0 : w_rd_word;
                            r_rresp <= {w_rbeat_err, 1'b0};
`else
                            r_rdata <= w_rd_word;
                            r_rresp <= 2'b00;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rvalid  = r_rvalid;
endmodule
